// File: rtl/mult_pkg.sv
// Shared encodings and sizing for the sequential multiplier controller.
package mult_pkg;
  localparam int MUL_ITERS = 32;
  localparam int CNT_W     = 5;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ABS_A  = 3'd1,
    S_ABS_B  = 3'd2,
    S_MUL    = 3'd3,
    S_NEG_LO = 3'd4,
    S_NEG_HI = 3'd5,
    S_DONE   = 3'd6
  } state_e;
endpackage

// File: rtl/adder32.sv
// Plain 32-bit ripple-carry adder; carry-out is intentionally not exposed.
module adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum
);
  logic [31:0] w_c;

  assign w_c[0] = cin;

  for (genvar gi = 0; gi < 32; gi++) begin : g_bit
    assign sum[gi] = a[gi] ^ b[gi] ^ w_c[gi];
    if (gi < 31) begin : g_carry
      assign w_c[gi+1] = (a[gi] & b[gi]) | ((a[gi] ^ b[gi]) & w_c[gi]);
    end
  end
endmodule

// File: rtl/mult_seq_ctrl.sv
// Multi-cycle MULT/MULTU: shift-add over one shared adder32, with optional
// sign handling (abs before, negate after) routed through the same adder.
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int SIGNED_EN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  state_e             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_mcand, r_hi, r_lo;
  logic               r_neg, r_sgn, r_c_lo;

  logic               w_signed, w_accept, w_last;
  logic [31:0]        w_x, w_y, w_sum;
  logic               w_cin, w_carry;

  assign w_signed = (SIGNED_EN != 0) && is_signed;
  assign w_accept = ((r_state == S_IDLE) || (r_state == S_DONE)) && start;
  assign w_last   = (r_cnt == CNT_W'(MUL_ITERS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) w_next = w_signed ? S_ABS_A : S_MUL;
        else       w_next = S_IDLE;
      end
      S_ABS_A:  w_next = S_ABS_B;
      S_ABS_B:  w_next = S_MUL;
      S_MUL:    if (w_last) w_next = r_sgn ? S_NEG_LO : S_DONE;
      S_NEG_LO: w_next = S_NEG_HI;
      S_NEG_HI: w_next = S_DONE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Operand mux: abs/negate are ~x + 1 (or ~hi + borrow-carry from the low word).
  always_comb begin
    w_x   = r_hi;
    w_y   = 32'd0;
    w_cin = 1'b0;
    case (r_state)
      S_ABS_A:  begin w_x = ~r_mcand; w_cin = 1'b1;   end
      S_ABS_B:  begin w_x = ~r_lo;    w_cin = 1'b1;   end
      S_MUL:    begin w_x = r_hi; w_y = r_lo[0] ? r_mcand : 32'd0; end
      S_NEG_LO: begin w_x = ~r_lo;    w_cin = 1'b1;   end
      S_NEG_HI: begin w_x = ~r_hi;    w_cin = r_c_lo; end
      default:  ;
    endcase
  end

  adder32 u_add (
    .a   (w_x),
    .b   (w_y),
    .cin (w_cin),
    .sum (w_sum)
  );

  // Recover bit-32 carry from the operand MSBs and the sum MSB.
  assign w_carry = (w_x[31] & w_y[31]) | ((w_x[31] ^ w_y[31]) & ~w_sum[31]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_mcand <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_neg   <= 1'b0;
      r_sgn   <= 1'b0;
      r_c_lo  <= 1'b0;
    end else if (w_accept) begin
      r_mcand <= op_a;
      r_lo    <= op_b;
      r_hi    <= '0;
      r_cnt   <= '0;
      r_neg   <= w_signed & (op_a[31] ^ op_b[31]);
      r_sgn   <= w_signed;
      r_c_lo  <= 1'b0;
    end else begin
      case (r_state)
        S_ABS_A: if (r_mcand[31]) r_mcand <= w_sum;
        S_ABS_B: if (r_lo[31])    r_lo    <= w_sum;
        S_MUL: begin
          r_hi  <= {w_carry, w_sum[31:1]};
          r_lo  <= {w_sum[0], r_lo[31:1]};
          r_cnt <= r_cnt + 1'b1;
        end
        S_NEG_LO: begin
          if (r_neg) begin
            r_lo   <= w_sum;
            r_c_lo <= w_carry;
          end else begin
            r_c_lo <= 1'b0;
          end
        end
        S_NEG_HI: if (r_neg) r_hi <= w_sum;
        default: ;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done = (r_state == S_DONE);
  assign hi   = r_hi;
  assign lo   = r_lo;
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl: products, latency, handshake and reset abort.
module tb_mult_seq_ctrl;
  logic        clk, rst_n, start, is_signed;
  logic [31:0] op_a, op_b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  mult_seq_ctrl #(.SIGNED_EN(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a request at the negedge so it is sampled at the next posedge.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
    op_a = a; op_b = b; is_signed = s; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    op_a = 32'hDEAD_BEEF; op_b = 32'hCAFE_F00D;
  endtask

  // Returns cycles after the accept cycle at which done is seen (n=1 is T+1).
  // Assumes the caller sits at the first negedge after the accept edge.
  task automatic wait_done(input int already, output int n);
    n = already;
    while (!done && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      failures++;
      checks++;
      $display("FAIL timeout: no done within %0d cycles", n);
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input int lat, input logic [31:0] eh,
                        input logic [31:0] el);
    int n;
    launch(a, b, s);
    wait_done(1, n);
    chk({tag, "_lat"}, 64'(n), 64'(lat));
    chk({tag, "_prod"}, {hi, lo}, {eh, el});
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    @(negedge clk);
    chk({tag, "_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int n, pulses;
    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; op_a = '0; op_b = '0;
    #1;
    chk("rst_state", {busy, done, hi, lo}, 66'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle", {busy, done}, 64'd0);

    run_op("u3x5",   32'd3,          32'd5,          1'b0, 33, 32'h0,        32'h0000000F);
    run_op("uffff",  32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, 33, 32'hFFFFFFFE, 32'h00000001);
    run_op("sm1x1",  32'hFFFFFFFF,   32'd1,          1'b1, 37, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op("sm7xm3", 32'hFFFFFFF9,   32'hFFFFFFFD,   1'b1, 37, 32'h0,        32'h00000015);
    run_op("smin2",  32'h80000000,   32'h80000000,   1'b1, 37, 32'h40000000, 32'h0);
    run_op("sminx1", 32'h80000000,   32'd1,          1'b1, 37, 32'hFFFFFFFF, 32'h80000000);
    run_op("s6xm2",  32'd6,          32'hFFFFFFFE,   1'b1, 37, 32'hFFFFFFFF, 32'hFFFFFFF4);

    // start mid-MUL is ignored
    launch(32'd1000, 32'd1000, 1'b0);
    repeat (8) @(negedge clk);
    chk("mid_busy", 64'(busy), 64'd1);
    op_a = 32'd7; op_b = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(10, n);
    chk("mid_lat", 64'(n), 64'd33);
    chk("mid_prod", {hi, lo}, 64'd1000000);

    // start held high in DONE: accepted there, next done 33 cycles later
    op_a = 32'h00010000; op_b = 32'h00010000; is_signed = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("chain_busy", 64'(busy), 64'd1);
    wait_done(1, n);
    chk("chain_lat", 64'(n), 64'd33);
    chk("chain_prod", {hi, lo}, 64'h0000000100000000);
    @(negedge clk);

    // reset during MUL iteration 10
    launch(32'h12345678, 32'h00000003, 1'b0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_zero", {busy, done, hi, lo}, 66'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    chk("abort_quiet", 64'(pulses), 64'd0);
    run_op("u2x2", 32'd2, 32'd2, 1'b0, 33, 32'h0, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
